// File: rtl/lcd_pkg.sv
// Shared types and constants for the LCD text writer.
// Holds the FSM state enum, default command bytes and bus sizing.
package lcd_pkg;

  typedef enum logic [1:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT_ACK,
    S_WAIT_DONE
  } state_e;

  localparam logic [7:0] LINE1_ADDR_DEF = 8'h80;
  localparam logic [7:0] LINE2_ADDR_DEF = 8'hC0;
  localparam logic [7:0] SPACE_CHAR     = 8'h20;
  localparam int         BUS_W          = 10;
  localparam int         SEQ_LEN        = 34;

endpackage

// File: rtl/lcd_char_buffer.sv
// Character register file: one write port, one combinational read port.
// Every entry resets to a space.
module lcd_char_buffer
  import lcd_pkg::*;
#(
  parameter int DEPTH = 32
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       wr_en,
  input  logic [4:0] wr_addr,
  input  logic [7:0] wr_data,
  input  logic [4:0] rd_addr,
  output logic [7:0] rd_data
);

  logic [7:0] mem_q [DEPTH];
  logic [7:0] mem_d [DEPTH];

  always_comb begin
    mem_d = mem_q;
    if (wr_en) begin
      mem_d[wr_addr] = wr_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= SPACE_CHAR;
      end
    end else begin
      mem_q <= mem_d;
    end
  end

  assign rd_data = mem_q[rd_addr];

endmodule

// File: rtl/lcd_text_writer.sv
// Pushes a two-line character buffer to an LCD controller
// as a sequence of handshaked command/data transfers.
module lcd_text_writer
  import lcd_pkg::*;
#(
  parameter int         CHARS_PER_LINE = 16,
  parameter logic [7:0] LINE1_ADDR     = LINE1_ADDR_DEF,
  parameter logic [7:0] LINE2_ADDR     = LINE2_ADDR_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             wr_en,
  input  logic [4:0]       wr_addr,
  input  logic [7:0]       wr_char,
  input  logic             refresh,
  input  logic             lcd_busy,
  output logic             lcd_enable,
  output logic [BUS_W-1:0] lcd_bus,
  output logic             active,
  output logic             done
);

  localparam int         DEPTH = 2 * CHARS_PER_LINE;
  localparam logic [5:0] CPL   = 6'(CHARS_PER_LINE);
  localparam logic [5:0] LAST  = 6'(2 * CHARS_PER_LINE + 1);

  state_e           state_q, state_d;
  logic [5:0]       idx_q, idx_d;
  logic             pending_q, pending_d;
  logic             active_q, active_d;
  logic             done_q, done_d;
  logic             en_q, en_d;
  logic [BUS_W-1:0] bus_q, bus_d;

  logic [4:0]       rd_addr;
  logic [7:0]       rd_data;
  logic [BUS_W-1:0] word;

  lcd_char_buffer #(
    .DEPTH (DEPTH)
  ) u_buf (
    .clk     (clk),
    .rst_n   (rst_n),
    .wr_en   (wr_en),
    .wr_addr (wr_addr),
    .wr_data (wr_char),
    .rd_addr (rd_addr),
    .rd_data (rd_data)
  );

  // Index 0 and CPL+1 are the line-address commands; skip them for reads.
  always_comb begin
    rd_addr = (idx_q <= CPL) ? 5'(idx_q - 6'd1)
                             : 5'(idx_q - 6'd2);
    word = {2'b10, rd_data};
    unique case (1'b1)
      (idx_q == 6'd0):       word = {2'b00, LINE1_ADDR};
      (idx_q == CPL + 6'd1): word = {2'b00, LINE2_ADDR};
      default:               word = {2'b10, rd_data};
    endcase
  end

  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    pending_d = pending_q;
    active_d  = active_q;
    done_d    = 1'b0;
    en_d      = en_q;
    bus_d     = bus_q;
    unique case (state_q)
      S_IDLE: begin
        en_d  = 1'b0;
        bus_d = '0;
        if (pending_q || (refresh && !done_q)) begin
          idx_d     = 6'd0;
          pending_d = 1'b0;
          active_d  = 1'b1;
          state_d   = S_ISSUE;
        end
      end
      S_ISSUE: begin
        if (!lcd_busy) begin
          en_d    = 1'b1;
          bus_d   = word;
          state_d = S_WAIT_ACK;
        end
      end
      S_WAIT_ACK: begin
        if (lcd_busy) begin
          en_d    = 1'b0;
          bus_d   = '0;
          state_d = S_WAIT_DONE;
        end
      end
      S_WAIT_DONE: begin
        if (!lcd_busy) begin
          if (idx_q == LAST) begin
            done_d   = 1'b1;
            active_d = 1'b0;
            state_d  = S_IDLE;
          end else begin
            idx_d   = idx_q + 6'd1;
            state_d = S_ISSUE;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
    // A done cycle counts as busy so that refresh there re-arms pending.
    if (refresh && (active_q || done_q)) begin
      pending_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      idx_q     <= 6'd0;
      pending_q <= 1'b0;
      active_q  <= 1'b0;
      done_q    <= 1'b0;
      en_q      <= 1'b0;
      bus_q     <= '0;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      pending_q <= pending_d;
      active_q  <= active_d;
      done_q    <= done_d;
      en_q      <= en_d;
      bus_q     <= bus_d;
    end
  end

  assign lcd_enable = en_q;
  assign lcd_bus    = bus_q;
  assign active     = active_q;
  assign done       = done_q;

endmodule

// File: tb/tb_lcd_text_writer.sv
// Directed bench for lcd_text_writer with a handshaking
// LCD controller model and protocol monitors.
module tb_lcd_text_writer;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       wr_en = 1'b0;
  logic [4:0] wr_addr = '0;
  logic [7:0] wr_char = '0;
  logic       refresh = 1'b0;
  logic       lcd_busy = 1'b0;
  logic       lcd_enable;
  logic [9:0] lcd_bus;
  logic       active;
  logic       done;

  lcd_text_writer dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .wr_en      (wr_en),
    .wr_addr    (wr_addr),
    .wr_char    (wr_char),
    .refresh    (refresh),
    .lcd_busy   (lcd_busy),
    .lcd_enable (lcd_enable),
    .lcd_bus    (lcd_bus),
    .active     (active),
    .done       (done)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int asrt_errs = 0;
  int done_cnt = 0;
  logic [9:0] xq[$];
  logic [7:0] bm[32];

  bit rnd_mode = 1'b0;
  bit force_busy = 1'b0;
  int m_state = 0;
  int m_cnt = 0;

  function automatic int ack_delay();
    return rnd_mode ? int'($urandom_range(1, 20)) : 1;
  endfunction

  function automatic int busy_len();
    if (!rnd_mode) return 1;
    if ($urandom_range(0, 7) == 0) return int'($urandom_range(1, 2000));
    return int'($urandom_range(1, 20));
  endfunction

  // Controller model: ack after a delay, stay busy, then release.
  always @(negedge clk) begin
    if (!rst_n) begin
      m_state = 0;
      lcd_busy = 1'b0;
    end else if (force_busy) begin
      lcd_busy = 1'b1;
    end else begin
      case (m_state)
        0: begin
          lcd_busy = 1'b0;
          if (lcd_enable) begin
            m_cnt = ack_delay() - 1;
            if (m_cnt == 0) begin
              lcd_busy = 1'b1;
              m_cnt = busy_len();
              m_state = 2;
            end else begin
              m_state = 1;
            end
          end
        end
        1: begin
          m_cnt--;
          if (m_cnt == 0) begin
            lcd_busy = 1'b1;
            m_cnt = busy_len();
            m_state = 2;
          end
        end
        default: begin
          m_cnt--;
          if (m_cnt == 0) begin
            lcd_busy = 1'b0;
            m_state = 0;
          end
        end
      endcase
    end
  end

  logic       prev_en = 1'b0;
  logic [9:0] prev_bus = '0;

  always @(negedge clk) begin
    if (rst_n) begin
      if (lcd_enable && !prev_en) xq.push_back(lcd_bus);
      if (done) done_cnt++;
      if (lcd_enable && prev_en && lcd_bus !== prev_bus) begin
        asrt_errs++;
        $display("FAIL assert_bus_stable got %h want %h", lcd_bus, prev_bus);
      end
      if (!lcd_enable && lcd_bus !== 10'h000) begin
        asrt_errs++;
        $display("FAIL assert_idle_bus got %h want 000", lcd_bus);
      end
      if (lcd_enable && !active) begin
        asrt_errs++;
        $display("FAIL assert_en_idle got en=1 active=0 want active=1");
      end
    end
    prev_en = lcd_enable;
    prev_bus = lcd_bus;
  end

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0h want %0h", name, act, exp);
    end
  endtask

  function automatic logic [9:0] exp_word(input int i);
    if (i == 0) return 10'h080;
    if (i == 17) return 10'h0C0;
    if (i <= 16) return {2'b10, bm[i-1]};
    return {2'b10, bm[i-2]};
  endfunction

  task automatic check_seq(input int base, input string tag);
    check({tag, "_count"}, xq.size() >= base + 34, 1);
    for (int i = 0; i < 34; i++) begin
      if (base + i < xq.size())
        check($sformatf("%s_x%0d", tag, i), int'(xq[base+i]),
              int'(exp_word(i)));
    end
  endtask

  task automatic pulse_refresh();
    @(negedge clk);
    refresh = 1'b1;
    @(negedge clk);
    refresh = 1'b0;
  endtask

  task automatic write_char(input logic [4:0] a, input logic [7:0] c);
    @(negedge clk);
    wr_en = 1'b1;
    wr_addr = a;
    wr_char = c;
    @(negedge clk);
    wr_en = 1'b0;
    bm[a] = c;
  endtask

  task automatic wait_done(input int target, input int budget,
                           input string name);
    int n = 0;
    while (done_cnt < target && n < budget) begin
      @(negedge clk);
      n++;
    end
    check({name, "_done_timeout"}, done_cnt >= target, 1);
  endtask

  task automatic wait_xfers(input int target, input int budget,
                            input string name);
    int n = 0;
    while (xq.size() < target && n < budget) begin
      @(negedge clk);
      n++;
    end
    check({name, "_xfer_timeout"}, xq.size() >= target, 1);
  endtask

  typedef struct {
    logic [4:0] addr;
    logic [7:0] chr;
    int         idx;
    logic [9:0] exp;
  } vec_t;

  vec_t vt[6];

  initial begin
    int b, d, n;
    bit bad;
    vt[0] = '{5'd0,  8'h41, 1,  10'h241};
    vt[1] = '{5'd31, 8'h5A, 33, 10'h25A};
    vt[2] = '{5'd15, 8'h7E, 16, 10'h27E};
    vt[3] = '{5'd16, 8'h30, 18, 10'h230};
    vt[4] = '{5'd5,  8'h00, 6,  10'h200};
    vt[5] = '{5'd20, 8'h61, 22, 10'h261};
    for (int i = 0; i < 32; i++) bm[i] = 8'h20;

    repeat (3) @(negedge clk);
    check("rst_enable", lcd_enable, 0);
    check("rst_bus", lcd_bus, 0);
    check("rst_active", active, 0);
    check("rst_done", done, 0);
    rst_n = 1'b1;

    // Plain refresh of a reset buffer
    b = xq.size();
    d = done_cnt;
    pulse_refresh();
    wait_done(d + 1, 5000, "basic");
    repeat (5) @(negedge clk);
    check("basic_size", xq.size(), b + 34);
    check_seq(b, "basic");
    check("basic_dones", done_cnt, d + 1);
    check("basic_active_end", active, 0);

    // Table-driven character placement
    foreach (vt[k]) write_char(vt[k].addr, vt[k].chr);
    b = xq.size();
    d = done_cnt;
    pulse_refresh();
    wait_done(d + 1, 5000, "table");
    foreach (vt[k]) begin
      if (b + vt[k].idx < xq.size())
        check($sformatf("table_v%0d", k), int'(xq[b+vt[k].idx]),
              int'(vt[k].exp));
      else
        check($sformatf("table_v%0d_missing", k), 0, 1);
    end

    // Controller busy on entry
    force_busy = 1'b1;
    b = xq.size();
    d = done_cnt;
    pulse_refresh();
    bad = 1'b0;
    repeat (500) begin
      @(negedge clk);
      if (lcd_enable) bad = 1'b1;
    end
    check("busy_hold_en", bad, 0);
    check("busy_hold_active", active, 1);
    force_busy = 1'b0;
    wait_done(d + 1, 5000, "busy");
    check("busy_size", xq.size(), b + 34);
    if (b < xq.size())
      check("busy_first", int'(xq[b]), 10'h080);

    // Two refreshes during one sequence collapse into one pending
    b = xq.size();
    d = done_cnt;
    pulse_refresh();
    wait_xfers(b + 5, 5000, "pend");
    pulse_refresh();
    repeat (3) @(negedge clk);
    pulse_refresh();
    wait_done(d + 2, 10000, "pend");
    repeat (50) @(negedge clk);
    check("pend_dones", done_cnt, d + 2);
    check("pend_size", xq.size(), b + 68);
    check("pend_active_end", active, 0);

    // Refresh landing in the done cycle
    b = xq.size();
    d = done_cnt;
    pulse_refresh();
    n = 0;
    while (done !== 1'b1 && n < 5000) begin
      @(negedge clk);
      n++;
    end
    check("atdone_seen", done, 1);
    refresh = 1'b1;
    @(negedge clk);
    refresh = 1'b0;
    wait_done(d + 2, 5000, "atdone");
    repeat (50) @(negedge clk);
    check("atdone_dones", done_cnt, d + 2);
    check("atdone_size", xq.size(), b + 68);

    // Write and refresh in the same cycle
    b = xq.size();
    d = done_cnt;
    @(negedge clk);
    wr_en = 1'b1;
    wr_addr = 5'd3;
    wr_char = 8'h55;
    refresh = 1'b1;
    @(negedge clk);
    wr_en = 1'b0;
    refresh = 1'b0;
    bm[3] = 8'h55;
    wait_done(d + 1, 5000, "wrref");
    if (b + 4 < xq.size())
      check("wrref_x4", int'(xq[b+4]), 10'h255);
    else
      check("wrref_missing", 0, 1);

    // Reset in the middle of a sequence
    b = xq.size();
    pulse_refresh();
    wait_xfers(b + 10, 5000, "midrst");
    @(negedge clk);
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    check("midrst_enable", lcd_enable, 0);
    check("midrst_active", active, 0);
    check("midrst_bus", lcd_bus, 0);
    rst_n = 1'b1;
    for (int i = 0; i < 32; i++) bm[i] = 8'h20;
    b = xq.size();
    repeat (100) @(negedge clk);
    check("midrst_quiet", xq.size(), b);
    check("midrst_idle", active, 0);
    d = done_cnt;
    pulse_refresh();
    wait_done(d + 1, 5000, "midrst");
    check_seq(b, "midrst");

    // Randomised controller timing
    rnd_mode = 1'b1;
    write_char(5'd7, 8'h48);
    write_char(5'd24, 8'h49);
    b = xq.size();
    d = done_cnt;
    pulse_refresh();
    wait_done(d + 1, 60000, "rnd");
    check_seq(b, "rnd");

    check("assertions", asrt_errs, 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
